// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: takes symbolic RV32I instruction fields over a
// valid/ready handshake and writes the encoded word into instruction memory
// at an auto-incrementing address.
// Supported ops: ADD, OR, ANDI, SLL, BNE, SH, LH (op_sel 7 is illegal).
// Optional feature macro: ENCODER_CHECKSUM_EN. When it is defined, checksum
// holds a running XOR of all written words. When it is undefined, checksum
// is tied to 0.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [12:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_OR   = 3'd1,
        OP_ANDI = 3'd2,
        OP_SLL  = 3'd3,
        OP_BNE  = 3'd4,
        OP_SH   = 3'd5,
        OP_LH   = 3'd6,
        OP_ILL  = 3'd7
    } op_t;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       enc_word;
    logic [ADDR_W:0]   count_inc;
    logic              accept;
    logic              legal;

    assign in_ready  = (state != FULL) && !flush && !reset;
    assign accept    = in_valid && in_ready;
    assign legal     = (op_sel != OP_ILL);
    assign count_inc = count + 1'b1;

    // Assemble the 32-bit RV32I word from the symbolic fields of the current beat.
    always_comb begin
        enc_word = '0;
        case (op_sel)
            OP_ADD:  enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
            OP_OR:   enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R};
            OP_SLL:  enc_word = {7'b0000000, rs2, rs1, 3'b001, rd, OPC_R};
            OP_ANDI: enc_word = {imm[11:0], rs1, 3'b111, rd, OPC_IMM};
            OP_LH:   enc_word = {imm[11:0], rs1, 3'b001, rd, OPC_LOAD};
            OP_SH:   enc_word = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], OPC_STORE};
            OP_BNE:  enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b001,
                                 imm[4:1], imm[11], OPC_BR};
            default: enc_word = '0;
        endcase
    end

    // Load FSM with registered write port, counters and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (flush) begin
            // The memory address and data registers keep their last values.
            // mem_we is low, so those values are never written.
            state  <= IDLE;
            ptr    <= '0;
            count  <= '0;
            full   <= 1'b0;
            err    <= 1'b0;
            mem_we <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            if (accept) begin
                if (!legal) begin
                    err <= 1'b1;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= enc_word;
                    ptr       <= ptr + 1'b1;
                    count     <= count_inc;
                    if (count_inc == DEPTH_C) begin
                        state <= FULL;
                        full  <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
            end
        end
    end

`ifdef ENCODER_CHECKSUM_EN
    logic [31:0] cs_q;

    // Running XOR of every written word, visible in the same cycle as mem_we.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cs_q <= '0;
        end else if (accept && legal) begin
            cs_q <= cs_q ^ enc_word;
        end
    end

    assign checksum = cs_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (DEPTH=4 instance).
// Directed program-loading scenarios followed by randomized beats, checked
// against a behavioural model that tracks only word count and running XOR.
module tb_instr_encoder_loader;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready;
    logic [2:0]        op_sel;
    logic [4:0]        rd, rs1, rs2;
    logic [12:0]       imm;
    logic              mem_we, full, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, checksum;
    logic [ADDR_W:0]   count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int          m_count = 0;
    logic [31:0] m_cs    = '0;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err(err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Encoding rules written as plain field arithmetic.
    function automatic logic [31:0] ref_enc(input int op, input int d, input int s1,
                                            input int s2, input int im);
        int unsigned u  = im & 32'h1FFF;
        int unsigned lo = u & 32'hFFF;
        int unsigned base_r = s2 * (1 << 20) + s1 * (1 << 15) + d * (1 << 7) + 51;
        case (op)
            0: return base_r;
            1: return base_r + 6 * (1 << 12);
            3: return base_r + 1 * (1 << 12);
            2: return lo * (1 << 20) + s1 * (1 << 15) + 7 * (1 << 12) + d * (1 << 7) + 19;
            6: return lo * (1 << 20) + s1 * (1 << 15) + 1 * (1 << 12) + d * (1 << 7) + 3;
            5: return (lo / 32) * (1 << 25) + s2 * (1 << 20) + s1 * (1 << 15)
                      + 1 * (1 << 12) + (lo % 32) * (1 << 7) + 35;
            4: return ((u >> 12) & 1) * (1 << 31) + ((u >> 5) & 63) * (1 << 25)
                      + s2 * (1 << 20) + s1 * (1 << 15) + 1 * (1 << 12)
                      + ((u >> 1) & 15) * (1 << 8) + ((u >> 11) & 1) * (1 << 7) + 99;
            default: return 32'h0;
        endcase
    endfunction

    // Apply one cycle of inputs and check the DUT against the model.
    task automatic step(input bit rst, input bit fl, input bit v, input int op,
                        input int d, input int s1, input int s2, input int im);
        bit          exp_ready, acc, exp_we, exp_err;
        logic [31:0] exp_word;
        int          exp_addr;
        reset = rst; flush = fl; in_valid = v;
        op_sel = 3'(op); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 13'(im);
        #1;
        exp_ready = (m_count != DEPTH) && !fl && !rst;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        exp_we = 0; exp_err = 0; exp_word = '0; exp_addr = 0;
        if (rst || fl) begin
            m_count = 0;
            m_cs    = '0;
        end else if (acc && op == 7) begin
            exp_err = 1;
        end else if (acc) begin
            exp_we   = 1;
            exp_word = ref_enc(op, d, s1, s2, im);
            exp_addr = m_count % (1 << ADDR_W);
            m_count++;
            m_cs ^= exp_word;
        end
        @(posedge clk);
        #1;
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("err", 32'(err), 32'(exp_err));
        check("count", 32'(count), 32'(m_count));
        check("full", 32'(full), 32'(m_count == DEPTH));
`ifdef ENCODER_CHECKSUM_EN
        check("checksum", checksum, m_cs);
`else
        check("checksum", checksum, 32'h0);
`endif
        if (exp_we) begin
            check("mem_addr", 32'(mem_addr), 32'(exp_addr));
            check("mem_wdata", mem_wdata, exp_word);
        end
        if (rst) begin
            check("rst_addr", 32'(mem_addr), 32'h0);
            check("rst_wdata", mem_wdata, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        op_sel = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        @(posedge clk); #1;

        // Reset state.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 2, 3, 0);   // beat during reset is ignored
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // ADD rd=1 rs1=2 rs2=3.
        step(0, 0, 1, 0, 1, 2, 3, 0);
        check("add_word", mem_wdata, 32'h003100B3);

        // ANDI then BNE back-to-back from a fresh start.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 5, 6, 0, 'h0FF);
        check("andi_word", mem_wdata, 32'h0FF37293);
        step(0, 0, 1, 4, 0, 1, 2, -8);
        check("bne_word", mem_wdata, 32'hFE209CE3);
        check("bne_addr", 32'(mem_addr), 32'd1);

        // SH, then an illegal op, then a legal beat.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 0, 8, 7, 4);
        check("sh_word", mem_wdata, 32'h00741223);
        step(0, 0, 1, 7, 3, 3, 3, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 9, 10, 11, 0);

        // Fill to DEPTH with in_valid held for five beats.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 3, i + 1, i + 2, i + 3, 0);
        step(0, 0, 1, 6, 4, 5, 0, 'h7FF);

        // Flush out of FULL with a beat presented, then load again at addr 0.
        step(0, 1, 1, 0, 1, 2, 3, 0);
        step(0, 0, 1, 6, 4, 5, 0, 'h800);
        check("post_flush_addr", 32'(mem_addr), 32'd0);

        // Flush arriving the cycle after an accepted write.
        step(0, 0, 1, 0, 2, 2, 2, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);

        // Randomized beats with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            int  r  = $urandom_range(0, 99);
            bit  rs = (r < 2);
            bit  fl = (r >= 2 && r < 9);
            step(rs, fl, ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 8191));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
